// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: CU op codes, flag bit positions,
// FSM state and iterative-datapath operation kinds, plus op classification helpers.
package alu_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd2;
    localparam logic [OP_W-1:0] OP_LSL  = 5'd3;
    localparam logic [OP_W-1:0] OP_LSR  = 5'd4;
    localparam logic [OP_W-1:0] OP_RSL  = 5'd5;
    localparam logic [OP_W-1:0] OP_RSR  = 5'd6;
    localparam logic [OP_W-1:0] OP_MUL  = 5'd7;
    localparam logic [OP_W-1:0] OP_DIV  = 5'd8;
    localparam logic [OP_W-1:0] OP_MOD  = 5'd9;
    localparam logic [OP_W-1:0] OP_AND  = 5'd10;
    localparam logic [OP_W-1:0] OP_OR   = 5'd11;
    localparam logic [OP_W-1:0] OP_XOR  = 5'd12;
    localparam logic [OP_W-1:0] OP_NOT  = 5'd13;
    localparam logic [OP_W-1:0] OP_INC  = 5'd14;
    localparam logic [OP_W-1:0] OP_DEC  = 5'd15;
    localparam logic [OP_W-1:0] OP_PSA  = 5'd16;
    localparam logic [OP_W-1:0] OP_PSB  = 5'd17;
    localparam logic [OP_W-1:0] OP_CMP  = 5'd18;
    localparam logic [OP_W-1:0] OP_LOG2 = 5'd20;
    localparam logic [OP_W-1:0] OP_SQRT = 5'd22;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        IT_MUL  = 2'd0,
        IT_DIV  = 2'd1,
        IT_SQRT = 2'd2
    } iter_op_e;

    // Codes the unit implements; everything else completes as illegal.
    function automatic logic is_legal(input logic [OP_W-1:0] op);
        logic ok;
        ok = 1'b0;
        if ((op >= OP_ADD && op <= OP_CMP) || op == OP_LOG2 || op == OP_SQRT) begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    // Ops handled by the bit-serial datapath.
    function automatic logic is_multi(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD) || (op == OP_SQRT);
    endfunction

    function automatic iter_op_e iter_kind(input logic [OP_W-1:0] op);
        iter_op_e k;
        k = IT_SQRT;
        if (op == OP_MUL) begin
            k = IT_MUL;
        end else if (op == OP_DIV || op == OP_MOD) begin
            k = IT_DIV;
        end
        return k;
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Bit-serial datapath shared by MUL (shift-add), DIV/MOD (restoring) and
// SQRT (non-restoring, two radicand bits per step).
// Ports: load_i latches operands/kind and clears the counter; step_i advances
// one iteration; last_c_o flags the terminal iteration; lo/hi/root_c_o are the
// post-step values so the caller can capture the final answer on the last edge.
module alu_iter
    import alu_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load_i,
    input  logic             step_i,
    input  iter_op_e         kind_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    output logic             last_c_o,
    output logic [W-1:0]     lo_c_o,
    output logic [W-1:0]     hi_c_o,
    output logic [W/2-1:0]   root_c_o
);

    localparam int unsigned CNT_W = $clog2(W);
    localparam int unsigned HW    = W / 2;

    iter_op_e         kind_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W:0]       acc_q, acc_d;   // MUL high half / DIV remainder / SQRT signed remainder
    logic [W-1:0]     q_q, q_d;       // MUL multiplier+low product / DIV dividend+quotient / SQRT radicand
    logic [W-1:0]     b_q;
    logic [HW-1:0]    root_q, root_d;

    logic [W:0]       mul_sum;
    logic [W:0]       div_sh;
    logic [W:0]       div_diff;
    logic             div_ge;
    logic [W:0]       sq_sh;
    logic [W:0]       sq_new;

    assign last_c_o = (kind_q == IT_SQRT) ? (cnt_q == CNT_W'(HW - 1)) : (cnt_q == CNT_W'(W - 1));
    assign lo_c_o   = q_d;
    assign hi_c_o   = acc_d[W-1:0];
    assign root_c_o = root_d;

    // Next-state for one iteration of the selected algorithm.
    always_comb begin
        acc_d  = acc_q;
        q_d    = q_q;
        root_d = root_q;
        cnt_d  = cnt_q;

        // Shift-add: add multiplicand when the current multiplier bit is set, then shift right.
        mul_sum = q_q[0] ? ({1'b0, acc_q[W-1:0]} + {1'b0, b_q}) : {1'b0, acc_q[W-1:0]};

        // Restoring division: bring down the next dividend bit and try to subtract.
        div_sh   = {acc_q[W-1:0], q_q[W-1]};
        div_ge   = (div_sh >= {1'b0, b_q});
        div_diff = div_sh - {1'b0, b_q};

        // Non-restoring sqrt: subtract 4Q+1 when remainder is non-negative, else add 4Q+3.
        sq_sh  = {acc_q[W-2:0], q_q[W-1:W-2]};
        sq_new = acc_q[W] ? (sq_sh + (W+1)'({root_q, 2'b11}))
                          : (sq_sh - (W+1)'({root_q, 2'b01}));

        if (load_i) begin
            acc_d  = '0;
            q_d    = a_i;
            root_d = '0;
            cnt_d  = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            case (kind_q)
                IT_MUL: begin
                    acc_d = {1'b0, mul_sum[W:1]};
                    q_d   = {mul_sum[0], q_q[W-1:1]};
                end
                IT_DIV: begin
                    acc_d = div_ge ? {1'b0, div_diff[W-1:0]} : {1'b0, div_sh[W-1:0]};
                    q_d   = {q_q[W-2:0], div_ge};
                end
                default: begin
                    acc_d  = sq_new;
                    q_d    = {q_q[W-3:0], 2'b00};
                    root_d = {root_q[HW-2:0], ~sq_new[W]};
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            kind_q <= IT_MUL;
            cnt_q  <= '0;
            acc_q  <= '0;
            q_q    <= '0;
            b_q    <= '0;
            root_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            q_q    <= q_d;
            root_q <= root_d;
            if (load_i) begin
                kind_q <= kind_i;
                b_q    <= b_i;
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle execution unit: single-cycle ops complete one edge after start,
// MUL/DIV/MOD/SQRT run through alu_iter. Result and {Z,N,C,V} flags are held
// until the next completion; illegal codes pulse illegal_o with done_o and
// leave result/flags untouched.
// Ports: start_i/op_select_i/opd_a_i/opd_b_i launch (sampled in IDLE only);
// busy_o, done_o, result_o, flags_o, illegal_o are all registered.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start_i,
    input  logic [OP_W-1:0]  op_select_i,
    input  logic [W-1:0]     opd_a_i,
    input  logic [W-1:0]     opd_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [W-1:0]     result_o,
    output logic [3:0]       flags_o,
    output logic             illegal_o
);

    state_e           state_q;
    logic [OP_W-1:0]  op_q;
    logic [W-1:0]     a_q;
    logic             b_zero_q;

    logic             accept_c;
    logic             it_last_c;
    logic [W-1:0]     it_lo_c, it_hi_c;
    logic [W/2-1:0]   it_root_c;

    logic [W:0]       add_t, sub_t, inc_t, dec_t, lsl_t, lsr_t;
    logic [W-1:0]     rol_t, ror_t, lg_t;
    int unsigned      sh;
    logic [W-1:0]     sc_res, sc_zn;
    logic             sc_c, sc_v;
    logic [3:0]       sc_flags;
    logic [W-1:0]     mc_res;
    logic             mc_c, mc_v;
    logic [3:0]       mc_flags;

    assign accept_c = (state_q == ST_IDLE) && start_i;

    alu_iter #(.W(W)) u_iter (
        .clk      (clk),
        .rst_b    (rst_b),
        .load_i   (accept_c && is_multi(op_select_i)),
        .step_i   (state_q == ST_RUN),
        .kind_i   (iter_kind(op_select_i)),
        .a_i      (opd_a_i),
        .b_i      (opd_b_i),
        .last_c_o (it_last_c),
        .lo_c_o   (it_lo_c),
        .hi_c_o   (it_hi_c),
        .root_c_o (it_root_c)
    );

    // Single-cycle ops, evaluated directly on the launch operands.
    always_comb begin
        add_t = {1'b0, opd_a_i} + {1'b0, opd_b_i};
        sub_t = {1'b0, opd_a_i} - {1'b0, opd_b_i};
        inc_t = {1'b0, opd_a_i} + (W+1)'(1);
        dec_t = {1'b0, opd_a_i} - (W+1)'(1);
        sh    = 32'(opd_b_i[3:0]) % W;
        // Extra bit on the exit side of a shift catches the last bit shifted out.
        lsl_t = {1'b0, opd_a_i} << sh;
        lsr_t = {opd_a_i, 1'b0} >> sh;
        rol_t = (opd_a_i << sh) | (opd_a_i >> (W - sh));
        ror_t = (opd_a_i >> sh) | (opd_a_i << (W - sh));
        lg_t  = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (opd_a_i[i]) begin
                lg_t = W'(i);
            end
        end

        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (op_select_i)
            OP_ADD: begin
                sc_res = add_t[W-1:0];
                sc_c   = add_t[W];
                sc_v   = (opd_a_i[W-1] == opd_b_i[W-1]) && (add_t[W-1] != opd_a_i[W-1]);
            end
            OP_SUB, OP_CMP: begin
                sc_res = (op_select_i == OP_CMP) ? opd_a_i : sub_t[W-1:0];
                sc_c   = sub_t[W];
                sc_v   = (opd_a_i[W-1] != opd_b_i[W-1]) && (sub_t[W-1] != opd_a_i[W-1]);
            end
            OP_INC: begin
                sc_res = inc_t[W-1:0];
                sc_c   = inc_t[W];
                sc_v   = !opd_a_i[W-1] && inc_t[W-1];
            end
            OP_DEC: begin
                sc_res = dec_t[W-1:0];
                sc_c   = dec_t[W];
                sc_v   = opd_a_i[W-1] && !dec_t[W-1];
            end
            OP_LSL: begin
                sc_res = lsl_t[W-1:0];
                sc_c   = lsl_t[W];
            end
            OP_LSR: begin
                sc_res = lsr_t[W:1];
                sc_c   = lsr_t[0];
            end
            OP_RSL: begin
                sc_res = rol_t;
                sc_c   = (sh != 0) && rol_t[0];
            end
            OP_RSR: begin
                sc_res = ror_t;
                sc_c   = (sh != 0) && ror_t[W-1];
            end
            OP_AND:  sc_res = opd_a_i & opd_b_i;
            OP_OR:   sc_res = opd_a_i | opd_b_i;
            OP_XOR:  sc_res = opd_a_i ^ opd_b_i;
            OP_NOT:  sc_res = ~opd_a_i;
            OP_PSA:  sc_res = opd_a_i;
            OP_PSB:  sc_res = opd_b_i;
            OP_LOG2: begin
                sc_res = lg_t;
                sc_v   = (opd_a_i == '0);
            end
            default: sc_res = '0;
        endcase

        // CMP reports Z/N of the difference while passing A through.
        sc_zn = (op_select_i == OP_CMP) ? sub_t[W-1:0] : sc_res;
        sc_flags         = '0;
        sc_flags[FLAG_Z] = (sc_zn == '0);
        sc_flags[FLAG_N] = sc_zn[W-1];
        sc_flags[FLAG_C] = sc_c;
        sc_flags[FLAG_V] = sc_v;
    end

    // Final answer of the iterative ops on their terminal step.
    always_comb begin
        mc_res = W'(it_root_c);
        mc_c   = 1'b0;
        mc_v   = 1'b0;
        case (op_q)
            OP_MUL: begin
                mc_res = it_lo_c;
                mc_c   = (it_hi_c != '0);
            end
            OP_DIV: begin
                mc_res = b_zero_q ? '1 : it_lo_c;
                mc_v   = b_zero_q;
            end
            OP_MOD: begin
                mc_res = b_zero_q ? a_q : it_hi_c;
                mc_v   = b_zero_q;
            end
            default: mc_res = W'(it_root_c);
        endcase
        mc_flags         = '0;
        mc_flags[FLAG_Z] = (mc_res == '0);
        mc_flags[FLAG_N] = mc_res[W-1];
        mc_flags[FLAG_C] = mc_c;
        mc_flags[FLAG_V] = mc_v;
    end

    // Control FSM and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_zero_q  <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            illegal_o <= 1'b0;
            result_o  <= '0;
            flags_o   <= '0;
        end else begin
            done_o    <= 1'b0;
            illegal_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        op_q     <= op_select_i;
                        a_q      <= opd_a_i;
                        b_zero_q <= (opd_b_i == '0);
                        busy_o   <= 1'b1;
                        if (is_multi(op_select_i)) begin
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_DONE;
                            done_o  <= 1'b1;
                            if (is_legal(op_select_i)) begin
                                result_o <= sc_res;
                                flags_o  <= sc_flags;
                            end else begin
                                illegal_o <= 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (it_last_c) begin
                        state_q  <= ST_DONE;
                        done_o   <= 1'b1;
                        result_o <= mc_res;
                        flags_o  <= mc_flags;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec (W=16).
module tb_alu_exec;
    import alu_pkg::*;

    localparam int unsigned W = 16;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            start_i;
    logic [4:0]      op_select_i;
    logic [W-1:0]    opd_a_i;
    logic [W-1:0]    opd_b_i;
    logic            busy_o;
    logic            done_o;
    logic [W-1:0]    result_o;
    logic [3:0]      flags_o;
    logic            illegal_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_exec #(.W(W)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .start_i     (start_i),
        .op_select_i (op_select_i),
        .opd_a_i     (opd_a_i),
        .opd_b_i     (opd_b_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .flags_o     (flags_o),
        .illegal_o   (illegal_o)
    );

    // Launch one op, scramble inputs afterwards, return cycles to done (-1 on timeout).
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic busy_ok);
        @(negedge clk);
        start_i = 1'b1; op_select_i = op; opd_a_i = a; opd_b_i = b;
        @(negedge clk);
        start_i = 1'b0; op_select_i = 5'd0; opd_a_i = 16'hDEAD; opd_b_i = 16'hBEEF;
        lat = 1;
        busy_ok = 1'b1;
        while (!done_o && lat < 64) begin
            if (!busy_o) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!busy_o) busy_ok = 1'b0;
        if (!done_o) lat = -1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; start_i = 1'b0; op_select_i = '0; opd_a_i = '0; opd_b_i = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_o); end
        n_cmp++; if (result_o !== 16'h0000) begin n_bad++; $display("FAIL reset_result: got %h want 0000", result_o); end
        n_cmp++; if (flags_o !== 4'h0) begin n_bad++; $display("FAIL reset_flags: got %h want 0", flags_o); end
        n_cmp++; if (illegal_o !== 1'b0) begin n_bad++; $display("FAIL reset_illegal: got %b want 0", illegal_o); end
        rst_b = 1'b1;
    endtask

    task automatic test_add_sub();
        int lat; logic bok;
        run_op(OP_ADD, 16'h7FFF, 16'h0001, lat, bok);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL add_latency: got %0d want 1", lat); end
        n_cmp++; if (result_o !== 16'h8000) begin n_bad++; $display("FAIL add_result: got %h want 8000", result_o); end
        n_cmp++; if (flags_o !== 4'b0101) begin n_bad++; $display("FAIL add_flags: got %b want 0101", flags_o); end
        n_cmp++; if (illegal_o !== 1'b0) begin n_bad++; $display("FAIL add_illegal: got %b want 0", illegal_o); end
        @(negedge clk);
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL add_busy_after: got %b want 0", busy_o); end
        run_op(OP_SUB, 16'h0005, 16'h0005, lat, bok);
        n_cmp++; if (result_o !== 16'h0000) begin n_bad++; $display("FAIL sub_result: got %h want 0000", result_o); end
        n_cmp++; if (flags_o !== 4'b1000) begin n_bad++; $display("FAIL sub_flags: got %b want 1000", flags_o); end
    endtask

    task automatic test_single_misc();
        int lat; logic bok;
        run_op(OP_CMP, 16'h0003, 16'h0005, lat, bok);
        n_cmp++; if (result_o !== 16'h0003) begin n_bad++; $display("FAIL cmp_result: got %h want 0003", result_o); end
        n_cmp++; if (flags_o !== 4'b0110) begin n_bad++; $display("FAIL cmp_flags: got %b want 0110", flags_o); end
        run_op(OP_DEC, 16'h0000, 16'h1234, lat, bok);
        n_cmp++; if (result_o !== 16'hFFFF) begin n_bad++; $display("FAIL dec_result: got %h want ffff", result_o); end
        n_cmp++; if (flags_o !== 4'b0110) begin n_bad++; $display("FAIL dec_flags: got %b want 0110", flags_o); end
        run_op(OP_XOR, 16'hFFFF, 16'h00FF, lat, bok);
        n_cmp++; if (result_o !== 16'hFF00) begin n_bad++; $display("FAIL xor_result: got %h want ff00", result_o); end
        n_cmp++; if (flags_o !== 4'b0100) begin n_bad++; $display("FAIL xor_flags: got %b want 0100", flags_o); end
        run_op(OP_LSR, 16'h0003, 16'h0001, lat, bok);
        n_cmp++; if (result_o !== 16'h0001) begin n_bad++; $display("FAIL lsr_result: got %h want 0001", result_o); end
        n_cmp++; if (flags_o !== 4'b0010) begin n_bad++; $display("FAIL lsr_flags: got %b want 0010", flags_o); end
        run_op(OP_LSL, 16'h0003, 16'h0011, lat, bok);
        n_cmp++; if (result_o !== 16'h0006) begin n_bad++; $display("FAIL lsl_amt_result: got %h want 0006", result_o); end
        n_cmp++; if (flags_o !== 4'b0000) begin n_bad++; $display("FAIL lsl_amt_flags: got %b want 0000", flags_o); end
    endtask

    task automatic test_rotate();
        int lat; logic bok;
        run_op(OP_RSL, 16'h8001, 16'h0001, lat, bok);
        n_cmp++; if (result_o !== 16'h0003) begin n_bad++; $display("FAIL rsl_result: got %h want 0003", result_o); end
        n_cmp++; if (flags_o !== 4'b0010) begin n_bad++; $display("FAIL rsl_flags: got %b want 0010", flags_o); end
        run_op(OP_RSR, 16'h0008, 16'h0004, lat, bok);
        n_cmp++; if (result_o !== 16'h8000) begin n_bad++; $display("FAIL rsr_result: got %h want 8000", result_o); end
        n_cmp++; if (flags_o !== 4'b0110) begin n_bad++; $display("FAIL rsr_flags: got %b want 0110", flags_o); end
    endtask

    task automatic test_mul();
        int lat; logic bok;
        run_op(OP_MUL, 16'h0100, 16'h0100, lat, bok);
        n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL mul_latency: got %0d want 17", lat); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL mul_busy: got %b want 1", bok); end
        n_cmp++; if (result_o !== 16'h0000) begin n_bad++; $display("FAIL mul_result: got %h want 0000", result_o); end
        n_cmp++; if (flags_o !== 4'b1010) begin n_bad++; $display("FAIL mul_flags: got %b want 1010", flags_o); end
        run_op(OP_MUL, 16'h0123, 16'h0011, lat, bok);
        n_cmp++; if (result_o !== 16'h1353) begin n_bad++; $display("FAIL mul2_result: got %h want 1353", result_o); end
    endtask

    task automatic test_divmod();
        int lat; logic bok;
        run_op(OP_DIV, 16'd100, 16'd7, lat, bok);
        n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL div_latency: got %0d want 17", lat); end
        n_cmp++; if (result_o !== 16'd14) begin n_bad++; $display("FAIL div_result: got %h want 000e", result_o); end
        n_cmp++; if (flags_o !== 4'b0000) begin n_bad++; $display("FAIL div_flags: got %b want 0000", flags_o); end
        run_op(OP_MOD, 16'd100, 16'd7, lat, bok);
        n_cmp++; if (result_o !== 16'd2) begin n_bad++; $display("FAIL mod_result: got %h want 0002", result_o); end
        run_op(OP_DIV, 16'h1234, 16'h0000, lat, bok);
        n_cmp++; if (result_o !== 16'hFFFF) begin n_bad++; $display("FAIL div0_result: got %h want ffff", result_o); end
        n_cmp++; if (flags_o !== 4'b0101) begin n_bad++; $display("FAIL div0_flags: got %b want 0101", flags_o); end
        run_op(OP_MOD, 16'h1234, 16'h0000, lat, bok);
        n_cmp++; if (result_o !== 16'h1234) begin n_bad++; $display("FAIL mod0_result: got %h want 1234", result_o); end
        n_cmp++; if (flags_o !== 4'b0001) begin n_bad++; $display("FAIL mod0_flags: got %b want 0001", flags_o); end
    endtask

    task automatic test_sqrt_log2();
        int lat; logic bok;
        run_op(OP_SQRT, 16'hFFFF, 16'h0000, lat, bok);
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL sqrt_latency: got %0d want 9", lat); end
        n_cmp++; if (result_o !== 16'h00FF) begin n_bad++; $display("FAIL sqrt_result: got %h want 00ff", result_o); end
        n_cmp++; if (flags_o !== 4'b0000) begin n_bad++; $display("FAIL sqrt_flags: got %b want 0000", flags_o); end
        run_op(OP_SQRT, 16'd1000, 16'h0000, lat, bok);
        n_cmp++; if (result_o !== 16'd31) begin n_bad++; $display("FAIL sqrt1000_result: got %h want 001f", result_o); end
        run_op(OP_LOG2, 16'h0400, 16'h0000, lat, bok);
        n_cmp++; if (result_o !== 16'd10) begin n_bad++; $display("FAIL log2_result: got %h want 000a", result_o); end
        run_op(OP_LOG2, 16'h0000, 16'h0000, lat, bok);
        n_cmp++; if (result_o !== 16'h0000) begin n_bad++; $display("FAIL log2z_result: got %h want 0000", result_o); end
        n_cmp++; if (flags_o !== 4'b1001) begin n_bad++; $display("FAIL log2z_flags: got %b want 1001", flags_o); end
    endtask

    task automatic test_start_during_run();
        int ndone; int first;
        ndone = 0; first = -1;
        @(negedge clk);
        start_i = 1'b1; op_select_i = OP_MUL; opd_a_i = 16'h0003; opd_b_i = 16'h0005;
        @(negedge clk);
        for (int i = 1; i <= 30; i++) begin
            if (done_o) begin
                ndone++;
                if (first < 0) first = i;
            end
            if (i == 4 || i == 17) begin
                start_i = 1'b1; op_select_i = OP_ADD; opd_a_i = 16'h0001; opd_b_i = 16'h0001;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL busy_start_dones: got %0d want 1", ndone); end
        n_cmp++; if (first !== 17) begin n_bad++; $display("FAIL busy_start_latency: got %0d want 17", first); end
        n_cmp++; if (result_o !== 16'h000F) begin n_bad++; $display("FAIL busy_start_result: got %h want 000f", result_o); end
    endtask

    task automatic test_illegal();
        int lat; logic bok;
        run_op(OP_ADD, 16'hFFFF, 16'h0001, lat, bok);
        n_cmp++; if (flags_o !== 4'b1010) begin n_bad++; $display("FAIL add_wrap_flags: got %b want 1010", flags_o); end
        run_op(5'd19, 16'h5555, 16'h3333, lat, bok);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL illegal_latency: got %0d want 1", lat); end
        n_cmp++; if (illegal_o !== 1'b1) begin n_bad++; $display("FAIL illegal_pulse: got %b want 1", illegal_o); end
        n_cmp++; if (result_o !== 16'h0000) begin n_bad++; $display("FAIL illegal_result: got %h want 0000", result_o); end
        n_cmp++; if (flags_o !== 4'b1010) begin n_bad++; $display("FAIL illegal_flags: got %b want 1010", flags_o); end
        @(negedge clk);
        n_cmp++; if (illegal_o !== 1'b0) begin n_bad++; $display("FAIL illegal_width: got %b want 0", illegal_o); end
    endtask

    task automatic test_reset_mid_div();
        int lat; logic bok; int ndone;
        run_op(OP_PSB, 16'h0000, 16'h5A5A, lat, bok);
        n_cmp++; if (result_o !== 16'h5A5A) begin n_bad++; $display("FAIL passb_result: got %h want 5a5a", result_o); end
        @(negedge clk);
        start_i = 1'b1; op_select_i = OP_DIV; opd_a_i = 16'd100; opd_b_i = 16'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        rst_b = 1'b0;
        #1;
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy_o); end
        n_cmp++; if (result_o !== 16'h0000) begin n_bad++; $display("FAIL abort_result: got %h want 0000", result_o); end
        n_cmp++; if (flags_o !== 4'h0) begin n_bad++; $display("FAIL abort_flags: got %b want 0000", flags_o); end
        @(negedge clk);
        rst_b = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_o) ndone++;
        end
        n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL abort_done: got %0d want 0", ndone); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got %b want 0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_single_misc();
        test_rotate();
        test_mul();
        test_divmod();
        test_sqrt_log2();
        test_start_during_run();
        test_illegal();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Multi-cycle execution unit driven by the control unit's 5-bit `op_select` code, sitting between register-file/immediate operand muxes and the write-back path. Accepts one operation per `start_i` pulse and returns result plus `{Z,N,C,V}` flags to the CU's `flags` input with a done pulse. Single-cycle ops finish in one cycle; MUL/DIV/MOD/SQRT iterate bit-serially.

## Interface

- `W`, 16, operand/result width (even, ≥4)
- `clk`  in  1  clock
- `rst_b`  in  1  reset; asynchronous, active-low; clock `clk`
- `start_i`  in  1  launch op; sampled only in IDLE
- `op_select_i`  in  5  op code (CU encoding)
- `opd_a_i`  in  W  operand A (destination register value)
- `opd_b_i`  in  W  operand B (source register or immediate)
- `busy_o`  out  1  op in flight (RUN or DONE)
- `done_o`  out  1  one-cycle completion pulse
- `result_o`  out  W  registered result, held until next done
- `flags_o`  out  4  `{Z,N,C,V}` = bits 3..0, held until next done
- `illegal_o`  out  1  one-cycle pulse with `done_o` for unsupported code

## Operation

- Codes: 1 ADD, 2 SUB, 3 LSL, 4 LSR, 5 RSL (rotate left), 6 RSR, 7 MUL, 8 DIV, 9 MOD, 10 AND, 11 OR, 12 XOR, 13 NOT A, 14 INC A, 15 DEC A, 16 PASS A, 17 PASS B, 18 CMP, 20 LOG2 A, 22 SQRT A. All others (0, 19, 21, 23–31) illegal.
- Operands and code latched at accepted start; inputs ignored afterward.
- Z = result==0, N = result[W-1], for every legal op. CMP: Z/N from A−B, result_o = A.
- ADD/INC: C = carry out, V = signed overflow. SUB/DEC/CMP: C = borrow (A<B unsigned), V = signed overflow.
- Shifts/rotates: amount = B[3:0] (mod W); C = last bit shifted/rotated out, 0 if amount 0; V=0.
- MUL: unsigned shift-add, result = low W bits; C = high half nonzero; V=0.
- DIV/MOD: unsigned restoring; B==0 → DIV result all ones, MOD result A, V=1, C=0.
- LOG2: floor(log2 A) via priority encoder; A==0 → result 0, V=1.
- SQRT: floor(sqrt A), non-restoring digit-by-digit, W/2 iterations.
- Logic, PASS, NOT, MUL, LOG2 (nonzero), SQRT: C=0/V=0 except as stated.
- Illegal: result_o and flags_o unchanged, illegal_o=1, done_o=1.
- FSM: IDLE → (start, single-cycle or illegal) DONE; IDLE → (start, MUL/DIV/MOD/SQRT) RUN; RUN → DONE when iteration counter hits terminal; DONE → IDLE unconditionally.
- Start while not IDLE (including the DONE cycle) ignored, not queued.

## Timing

- Reset: FSM IDLE, counter 0, result_o=0, flags_o=0, busy_o=0, done_o=0, illegal_o=0.
- Single-cycle/illegal: done_o high in cycle after start edge (latency 1).
- MUL/DIV/MOD: W RUN cycles, done_o at latency W+1 (17 for W=16).
- SQRT: W/2 RUN cycles, latency W/2+1 (9).
- result_o/flags_o update on the same edge done_o rises; busy_o falls the cycle after done.
- Reset mid-RUN aborts: all outputs return to reset values, no done pulse.
- Back-to-back throughput: next start accepted the cycle after DONE (1 idle cycle min).

## Structure

- `alu_pkg`: op-code localparams (OP_ADD..OP_SQRT), flag bit indices (FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0), FSM state typedef.
- One sub-module `alu_iter`: shared W-bit shift/accumulate datapath with counter for MUL/DIV/MOD/SQRT; top holds FSM, combinational single-cycle ops, output registers.

## Test plan

- ADD A=0x7FFF, B=0x0001 → result 0x8000, flags N=1 V=1 C=0 Z=0, done 1 cycle after start; SUB 5−5 → 0x0000, Z=1 C=0.
- MUL 0x0100×0x0100 → result 0x0000, Z=1 C=1, done exactly 17 cycles after start, busy high throughout.
- DIV 100/7 → 14, MOD → 2; DIV 0x1234/0 → 0xFFFF with V=1; MOD 0x1234/0 → 0x1234, V=1.
- SQRT 0xFFFF → 0x00FF at latency 9; LOG2 0x0400 → 10; LOG2 0 → 0, Z=1 V=1.
- RSL A=0x8001, B=1 → 0x0003, C=1; start pulsed during MUL RUN ignored (single done, MUL result).
- Op 19 after ADD → illegal_o+done_o pulse, result/flags retain ADD values; rst_b low mid-DIV → outputs zero, no done.
